// File: rtl/sa_blkbox_pkg.sv
// Shared types and helpers for the black-box stream sink and its signature logic.
// No logic of its own; pure declarations.
// Not applicable: no handshake here.
package sa_blkbox_pkg;

  // Packet-tracking state: between packets, or inside a multi-beat packet.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_INPKT = 1'b1
  } pkt_state_e;

  // CRC-32 generator polynomial, used as the default MISR feedback.
  localparam logic [31:0] DEFAULT_POLY = 32'h04C11DB7;

  // Increment that sticks at max_v instead of wrapping.
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input logic [63:0] max_v);
    return (v >= max_v) ? v : v + 64'd1;
  endfunction

endpackage

// File: rtl/sa_blkbox_sink_if.sv
// Valid/ready stream bundle: valid, ready, data and end-of-packet marker.
// Wires only, no latency.
// Ready flows from the slave back to the master.
interface sa_blkbox_sink_if #(
  parameter int DW = 32
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_last;

  modport master (output in_valid, output in_data, output in_last, input in_ready);
  modport slave  (input in_valid, input in_data, input in_last, output in_ready);
endinterface

// File: rtl/sa_blkbox_misr.sv
// Multiple-input signature register: folds one data word per enabled cycle.
// Signature reflects an enabled word one cycle later.
// No handshake; en qualifies the input, clr wins over en.
module sa_blkbox_misr import sa_blkbox_pkg::*; #(
  parameter int            DW   = 32,
  parameter logic [DW-1:0] POLY = DW'(DEFAULT_POLY)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          clr,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] sig
);

  logic [DW-1:0] sig_q, sig_d;

  // Next signature: clear, shift-with-feedback plus data, or hold.
  always_comb begin
    sig_d = sig_q;
    if (clr) begin
      sig_d = '0;
    end else if (en) begin
      sig_d = {sig_q[DW-2:0], 1'b0} ^ (sig_q[DW-1] ? POLY : '0) ^ d;
    end
  end

  // Signature register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sig_q <= '0;
    else     sig_q <= sig_d;
  end

  assign sig = sig_q;

endmodule

// File: rtl/sa_blkbox_sink.sv
// Terminating sink for dangling streams: counts beats/packets, signs data, flags violations.
// Every accepted beat shows on the status outputs one cycle later; nothing is stored.
// Ready is registered and free-running: always on, or one cycle in THROTTLE+1.
module sa_blkbox_sink import sa_blkbox_pkg::*; #(
  parameter int            DW       = 32,
  parameter int            CNT_W    = 16,
  parameter logic [DW-1:0] POLY     = DW'(DEFAULT_POLY),
  parameter int            THROTTLE = 0
) (
  input  logic             core_clk,
  input  logic             core_rst,
  sa_blkbox_sink_if.slave  s,
  input  logic             clr,
  output logic [CNT_W-1:0] beat_cnt,
  output logic [CNT_W-1:0] pkt_cnt,
  output logic [DW-1:0]    sig,
  output logic             nz_seen,
  output logic             proto_err,
  output logic             in_pkt
);

  localparam int          TW      = (THROTTLE > 0) ? $clog2(THROTTLE + 1) : 1;
  localparam logic [63:0] CNT_MAX = (64'd1 << CNT_W) - 64'd1;

  logic [TW-1:0]    thr_q, thr_d;
  logic             rdy_q, rdy_d;
  logic [CNT_W-1:0] beat_q, beat_d, pkt_q, pkt_d;
  logic             nz_q, nz_d, perr_q, perr_d;
  logic             pend_q, last_q;
  logic [DW-1:0]    dat_q;
  pkt_state_e       state_q, state_d;
  logic             acc, viol;

  assign acc = s.in_valid & rdy_q;

  // A stalled beat must be held unchanged until it is taken.
  assign viol = pend_q & (~s.in_valid | (s.in_data != dat_q) | (s.in_last != last_q));

  // Throttle phase counter wraps at THROTTLE; ready is asserted for phase 0.
  always_comb begin
    thr_d = (thr_q == TW'(THROTTLE)) ? '0 : thr_q + TW'(1);
    rdy_d = (thr_q == '0);
  end

  // Counters and sticky flags; clr overrides a coincident accept.
  always_comb begin
    beat_d = beat_q;
    pkt_d  = pkt_q;
    nz_d   = nz_q;
    perr_d = perr_q | viol;
    if (clr) begin
      beat_d = '0;
      pkt_d  = '0;
      nz_d   = 1'b0;
      perr_d = 1'b0;
    end else if (acc) begin
      beat_d = CNT_W'(sat_inc(64'(beat_q), CNT_MAX));
      if (s.in_last) pkt_d = CNT_W'(sat_inc(64'(pkt_q), CNT_MAX));
      if (s.in_data != '0) nz_d = 1'b1;
    end
  end

  // Packet FSM next state: open on a non-last beat, close on a last beat.
  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = ST_IDLE;
    end else if (acc) begin
      case (state_q)
        ST_IDLE:  if (!s.in_last) state_d = ST_INPKT;
        ST_INPKT: if (s.in_last)  state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // All state registers, cleared immediately on reset.
  always_ff @(posedge core_clk or posedge core_rst) begin
    if (core_rst) begin
      thr_q   <= '0;
      rdy_q   <= 1'b0;
      beat_q  <= '0;
      pkt_q   <= '0;
      nz_q    <= 1'b0;
      perr_q  <= 1'b0;
      pend_q  <= 1'b0;
      dat_q   <= '0;
      last_q  <= 1'b0;
      state_q <= ST_IDLE;
    end else begin
      thr_q   <= thr_d;
      rdy_q   <= rdy_d;
      beat_q  <= beat_d;
      pkt_q   <= pkt_d;
      nz_q    <= nz_d;
      perr_q  <= perr_d;
      pend_q  <= s.in_valid & ~rdy_q;
      dat_q   <= s.in_data;
      last_q  <= s.in_last;
      state_q <= state_d;
    end
  end

  sa_blkbox_misr #(.DW(DW), .POLY(POLY)) u_misr (
    .clk (core_clk),
    .rst (core_rst),
    .en  (acc),
    .clr (clr),
    .d   (s.in_data),
    .sig (sig)
  );

  assign s.in_ready = rdy_q;
  assign beat_cnt   = beat_q;
  assign pkt_cnt    = pkt_q;
  assign nz_seen    = nz_q;
  assign proto_err  = perr_q;
  assign in_pkt     = (state_q == ST_INPKT);

endmodule

// File: tb/tb_sa_blkbox_sink.sv
// Bench for sa_blkbox_sink: two instances (free-running ready, and THROTTLE=2 with 2-bit counters).
// A cycle-level reference model is compared against both every cycle.
// Directed literal checks pin the model; randomized traffic covers stalls, clears and violations.
module tb_sa_blkbox_sink;

  localparam logic [31:0] POLY_T = 32'h04C11DB7;

  logic core_clk, core_rst;
  logic v[2];
  logic [31:0] d[2];
  logic l[2];
  logic c[2];

  int n_cmp = 0;
  int n_err = 0;
  bit cmp_en = 0;

  sa_blkbox_sink_if #(.DW(32)) if0 ();
  sa_blkbox_sink_if #(.DW(32)) if1 ();

  assign if0.in_valid = v[0];
  assign if0.in_data  = d[0];
  assign if0.in_last  = l[0];
  assign if1.in_valid = v[1];
  assign if1.in_data  = d[1];
  assign if1.in_last  = l[1];

  logic [15:0] b0, p0;
  logic [1:0]  b1, p1;
  logic [31:0] s0, s1;
  logic nz0, nz1, pe0, pe1, ip0, ip1;

  sa_blkbox_sink #(.DW(32), .CNT_W(16), .POLY(POLY_T), .THROTTLE(0)) u0 (
    .core_clk(core_clk), .core_rst(core_rst), .s(if0), .clr(c[0]),
    .beat_cnt(b0), .pkt_cnt(p0), .sig(s0), .nz_seen(nz0), .proto_err(pe0), .in_pkt(ip0)
  );

  sa_blkbox_sink #(.DW(32), .CNT_W(2), .POLY(POLY_T), .THROTTLE(2)) u1 (
    .core_clk(core_clk), .core_rst(core_rst), .s(if1), .clr(c[1]),
    .beat_cnt(b1), .pkt_cnt(p1), .sig(s1), .nz_seen(nz1), .proto_err(pe1), .in_pkt(ip1)
  );

  initial begin
    core_clk = 1'b0;
    forever #5 core_clk = ~core_clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  int          m_beat[2], m_pkt[2], m_k[2];
  logic [31:0] m_sig[2], m_pd[2];
  bit          m_nz[2], m_pe[2], m_ip[2], m_rdy[2], m_pend[2], m_pl[2];

  function automatic int thr(int i);
    return (i == 0) ? 0 : 2;
  endfunction

  function automatic int maxc(int i);
    return (i == 0) ? 65535 : 3;
  endfunction

  function automatic logic [31:0] misr(logic [31:0] s, logic [31:0] x);
    return {s[30:0], 1'b0} ^ (s[31] ? POLY_T : 32'h0) ^ x;
  endfunction

  always @(posedge core_clk or posedge core_rst) begin
    if (core_rst) begin
      for (int i = 0; i < 2; i++) begin
        m_beat[i] <= 0; m_pkt[i] <= 0; m_k[i] <= 0; m_sig[i] <= '0; m_pd[i] <= '0;
        m_nz[i] <= 0; m_pe[i] <= 0; m_ip[i] <= 0; m_rdy[i] <= 0; m_pend[i] <= 0; m_pl[i] <= 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        bit acc, viol;
        acc  = v[i] && m_rdy[i];
        viol = m_pend[i] && (!v[i] || d[i] != m_pd[i] || l[i] != m_pl[i]);
        m_pend[i] <= v[i] && !m_rdy[i];
        m_pd[i]   <= d[i];
        m_pl[i]   <= l[i];
        // ready after edge number k+1 is high when k is a multiple of the period
        m_rdy[i]  <= (m_k[i] % (thr(i) + 1)) == 0;
        m_k[i]    <= m_k[i] + 1;
        if (c[i]) begin
          m_beat[i] <= 0; m_pkt[i] <= 0; m_sig[i] <= '0; m_nz[i] <= 0; m_pe[i] <= 0; m_ip[i] <= 0;
        end else begin
          if (acc) begin
            m_beat[i] <= (m_beat[i] < maxc(i)) ? m_beat[i] + 1 : m_beat[i];
            if (l[i]) m_pkt[i] <= (m_pkt[i] < maxc(i)) ? m_pkt[i] + 1 : m_pkt[i];
            m_sig[i] <= misr(m_sig[i], d[i]);
            if (d[i] != 0) m_nz[i] <= 1;
            m_ip[i] <= !l[i];
          end
          if (viol) m_pe[i] <= 1;
        end
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_inst(int i, logic rdy, logic [63:0] b, logic [63:0] p, logic [31:0] s,
                          logic nz, logic pe, logic ip);
    chk($sformatf("u%0d_ready", i), 64'(rdy), 64'(m_rdy[i]));
    chk($sformatf("u%0d_beat", i),  b, 64'(m_beat[i]));
    chk($sformatf("u%0d_pkt", i),   p, 64'(m_pkt[i]));
    chk($sformatf("u%0d_sig", i),   64'(s), 64'(m_sig[i]));
    chk($sformatf("u%0d_nz", i),    64'(nz), 64'(m_nz[i]));
    chk($sformatf("u%0d_perr", i),  64'(pe), 64'(m_pe[i]));
    chk($sformatf("u%0d_inpkt", i), 64'(ip), 64'(m_ip[i]));
  endtask

  always @(negedge core_clk) begin
    if (cmp_en && !core_rst) begin
      cmp_inst(0, if0.in_ready, 64'(b0), 64'(p0), s0, nz0, pe0, ip0);
      cmp_inst(1, if1.in_ready, 64'(b1), 64'(p1), s1, nz1, pe1, ip1);
    end
  end

  // Present one beat on instance i and hold it until an edge takes it.
  task automatic hs(int i, logic [31:0] dat, logic lst);
    logic r;
    int n;
    v[i] = 1'b1; d[i] = dat; l[i] = lst;
    n = 0;
    do begin
      r = (i == 0) ? if0.in_ready : if1.in_ready;
      @(posedge core_clk); #1;
      n++;
    end while (!r && n < 20);
    chk($sformatf("u%0d_handshake_taken", i), 64'(r), 64'd1);
    v[i] = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic r[9];
    logic rr0, rr1, hold;
    int ones;
    for (int i = 0; i < 2; i++) begin v[i] = 0; d[i] = 0; l[i] = 0; c[i] = 0; end
    core_rst = 1'b1;
    repeat (3) @(posedge core_clk);
    #1 core_rst = 1'b0;
    cmp_en = 1;

    // reset state, before the first post-release edge
    @(negedge core_clk);
    chk("rst_ready0", 64'(if0.in_ready), 64'd0);
    chk("rst_ready1", 64'(if1.in_ready), 64'd0);
    chk("rst_beat0", 64'(b0), 64'd0);
    chk("rst_sig0", 64'(s0), 64'd0);
    @(posedge core_clk); #1;
    chk("ready0_after_first_edge", 64'(if0.in_ready), 64'd1);

    // three zero beats, last on the third
    hs(0, 32'h0, 1'b0);
    chk("t1_inpkt_after_beat1", 64'(ip0), 64'd1);
    hs(0, 32'h0, 1'b0);
    hs(0, 32'h0, 1'b1);
    chk("t1_beat", 64'(b0), 64'd3);
    chk("t1_pkt", 64'(p0), 64'd1);
    chk("t1_sig", 64'(s0), 64'd0);
    chk("t1_nz", 64'(nz0), 64'd0);
    chk("t1_inpkt_after_beat3", 64'(ip0), 64'd0);

    // single-beat packets: data 1 then data 0
    hs(0, 32'h1, 1'b1);
    chk("t2_sig1", 64'(s0), 64'h1);
    chk("t2_nz", 64'(nz0), 64'd1);
    hs(0, 32'h0, 1'b1);
    chk("t2_sig2", 64'(s0), 64'h2);
    chk("t2_pkt", 64'(p0), 64'd3);

    // throttled instance: align so the next two ready samples are 0, then hold valid 9 cycles
    while (!if1.in_ready) begin @(posedge core_clk); #1; end
    @(posedge core_clk); #1;
    v[1] = 1'b1; d[1] = 32'h5; l[1] = 1'b1;
    ones = 0;
    for (int j = 0; j < 9; j++) begin
      r[j] = if1.in_ready;
      if (r[j]) ones++;
      @(posedge core_clk); #1;
    end
    v[1] = 1'b0;
    chk("thr_ready_ones", 64'(ones), 64'd3);
    for (int j = 0; j < 6; j++) chk($sformatf("thr_pattern_%0d", j), 64'(r[j + 3]), 64'(r[j]));
    chk("thr_first_ready", 64'(r[2]), 64'd1);
    chk("thr_beats", 64'(b1), 64'd3);
    chk("thr_no_perr", 64'(pe1), 64'd0);

    // saturation with 2-bit counters
    for (int j = 0; j < 5; j++) hs(1, 32'hA0 + 32'(j), 1'b1);
    chk("sat_beat", 64'(b1), 64'd3);
    chk("sat_pkt", 64'(p1), 64'd3);

    // valid retracted while stalled: ready is 0 right after an accepting edge
    v[1] = 1'b1; d[1] = 32'h9; l[1] = 1'b0;
    @(posedge core_clk); #1;
    v[1] = 1'b0;
    @(posedge core_clk); #1;
    chk("perr_set", 64'(pe1), 64'd1);

    // clr together with an accepted beat
    c[1] = 1'b1;
    hs(1, 32'h7, 1'b1);
    c[1] = 1'b0;
    chk("clr_beat", 64'(b1), 64'd0);
    chk("clr_pkt", 64'(p1), 64'd0);
    chk("clr_sig", 64'(s1), 64'd0);
    chk("clr_nz", 64'(nz1), 64'd0);
    chk("clr_perr", 64'(pe1), 64'd0);

    // randomized traffic: mostly legal stalls, occasional violations and clears
    for (int n = 0; n < 2000; n++) begin
      rr0 = if0.in_ready;
      rr1 = if1.in_ready;
      @(posedge core_clk); #1;
      for (int i = 0; i < 2; i++) begin
        hold = v[i] && !((i == 0) ? rr0 : rr1);
        c[i] = ($urandom_range(0, 63) == 0);
        if (!hold || $urandom_range(0, 31) == 0) begin
          v[i] = ($urandom_range(0, 2) != 0);
          d[i] = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
          l[i] = ($urandom_range(0, 3) == 0);
        end
      end
    end
    for (int i = 0; i < 2; i++) begin v[i] = 0; c[i] = 0; end
    @(posedge core_clk); #1;

    // asynchronous reset in the middle of a packet
    hs(0, 32'h3, 1'b0);
    chk("arst_pre_inpkt", 64'(ip0), 64'd1);
    #2 core_rst = 1'b1;
    #1;
    chk("arst_ready", 64'(if0.in_ready), 64'd0);
    chk("arst_inpkt", 64'(ip0), 64'd0);
    chk("arst_beat", 64'(b0), 64'd0);
    chk("arst_pkt", 64'(p0), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
